// File: rtl/sumator_seq_pkg.sv
// Shared constants and types for the sequential multi-word adder/subtractor.
// Word width, FSM state encoding, operation encoding and the overflow helper.
package sumator_seq_pkg;

  localparam int WORD_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/sumator16b.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with group P/G
// lookahead. Per-bit propagate, generate and carry-in are exported for debug.
module sumator16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic [15:0] p,
  output logic [15:0] g,
  output logic [15:0] c
);

  logic [3:0] gp_s;
  logic [3:0] gg_s;
  logic [4:0] gc_s;

  // Bit and group propagate/generate, group carries, then bit carries and sum.
  always_comb begin
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < 4; j++) begin
      gp_s[j] = &p[4*j +: 4];
      gg_s[j] = g[4*j+3]
              | (p[4*j+3] & g[4*j+2])
              | (p[4*j+3] & p[4*j+2] & g[4*j+1])
              | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end

    gc_s[0] = cin;
    gc_s[1] = gg_s[0] | (gp_s[0] & cin);
    gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
    gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
    gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
            | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);

    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc_s[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc_s[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc_s[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc_s[j]);
    end

    s    = p ^ c;
    cout = gc_s[4];
  end

endmodule

// File: rtl/sumator_seq.sv
// Sequential NWORDS x 16-bit adder/subtractor: one word per clock through a
// single carry-lookahead adder, carry chained through a register between words.
module sumator_seq
  import sumator_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       op,
  input  logic [WORD_W*NWORDS-1:0]   a,
  input  logic [WORD_W*NWORDS-1:0]   b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [WORD_W*NWORDS-1:0]   sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int DATA_W = WORD_W * NWORDS;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t              state_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic                carry_r;
  logic [IDXW-1:0]     idx_r;

  logic [WORD_W-1:0]   a_word_s;
  logic [WORD_W-1:0]   b_word_s;
  logic [WORD_W-1:0]   word_sum_s;
  logic                word_cout_s;

  // Select the operand words for the current index.
  always_comb begin
    a_word_s = a_r[WORD_W*int'(idx_r) +: WORD_W];
    b_word_s = b_r[WORD_W*int'(idx_r) +: WORD_W];
  end

  sumator16b u_word_add (
    .a    (a_word_s),
    .b    (b_word_s),
    .cin  (carry_r),
    .s    (word_sum_s),
    .cout (word_cout_s),
    .p    (),
    .g    (),
    .c    ()
  );

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
      sum     <= {DATA_W{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1; b is stored already inverted.
            a_r     <= a;
            b_r     <= (op == OP_SUB) ? ~b : b;
            carry_r <= (op == OP_SUB) ? 1'b1 : cin;
            idx_r   <= {IDXW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          sum[WORD_W*int'(idx_r) +: WORD_W] <= word_sum_s;
          carry_r <= word_cout_s;
          if (idx_r == LAST_IDX) begin
            cout    <= word_cout_s;
            ovf     <= signed_ovf(a_r[DATA_W-1], b_r[DATA_W-1], word_sum_s[WORD_W-1]);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumator_seq.sv
// Directed bench for sumator_seq (NWORDS=4): expected results come from a
// full-width reference model, queued on issue and popped when done pulses.
module tb_sumator_seq;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  always #5 clk = ~clk;

  sumator_seq #(.NWORDS(NW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic opi, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] be;
    exp_t         e;
    be     = opi ? ~bi : bi;
    full   = {1'b0, ai} + {1'b0, be} + {{W{1'b0}}, (opi ? 1'b1 : ci)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ai[W-1] == be[W-1]) && (e.sum[W-1] != ai[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge; the accept happens at the next posedge.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic opi, input logic ci, input bit hold);
    a = ai; b = bi; op = opi; cin = ci; start = 1'b1;
    sb.push_back(model(ai, bi, opi, ci));
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int edges0, input int busy0);
    int   edges;
    int   bcnt;
    exp_t e;
    edges = edges0;
    bcnt  = busy0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (busy === 1'b1) bcnt++;
    end
    chk({tag, "_done"}, W'(done), W'(1'b1));
    chk({tag, "_latency"}, W'(edges), W'(NW));
    chk({tag, "_busycycles"}, W'(bcnt), W'(NW));
    e = sb.pop_front();
    last_e = e;
    chk({tag, "_sum"}, sum, e.sum);
    chk({tag, "_cout"}, W'(cout), W'(e.cout));
    chk({tag, "_ovf"}, W'(ovf), W'(e.ovf));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, W'(done), W'(1'b0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", W'(busy), W'(1'b0));
    chk("reset_done", W'(done), W'(1'b0));
    chk("reset_sum", sum, '0);
    chk("reset_cout", W'(cout), W'(1'b0));
    chk("reset_ovf", W'(ovf), W'(1'b0));
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    wait_done("add_wrap", 0, int'(busy));

    issue(64'h5, 64'h7, 1'b1, 1'b1, 1'b0);
    wait_done("sub_borrow", 0, int'(busy));

    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    wait_done("add_ovf", 0, int'(busy));

    // Operands change and a second start arrives mid-operation; both ignored.
    issue(64'hFFFF, 64'h0, 1'b0, 1'b1, 1'b0);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_2222_3333_4444; op = 1'b1; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignored_busy", W'(busy), W'(1'b1));
    wait_done("word_carry", 2, 3);
    repeat (3) begin
      chk("no_queued_op", W'(busy), W'(1'b0));
      @(posedge clk); #1;
    end
    chk("hold_sum", sum, last_e.sum);
    chk("hold_cout", W'(cout), W'(last_e.cout));

    // Reset in the second RUN cycle aborts the operation.
    issue(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", W'(busy), W'(1'b0));
    chk("abort_done", W'(done), W'(1'b0));
    chk("abort_sum", sum, '0);
    issue(64'h3, 64'h4, 1'b0, 1'b0, 1'b0);
    wait_done("after_abort", 0, int'(busy));

    // Start held high: exactly one IDLE cycle between done and the next RUN.
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0));
    wait_done("b2b_first", 0, int'(busy));
    chk("b2b_idle", W'(busy), W'(1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rerun", W'(busy), W'(1'b1));
    wait_done("b2b_second", 0, int'(busy));

    for (int i = 0; i < 4; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'(i % 2), 1'($urandom_range(1, 0)), 1'b0);
      wait_done("random", 0, int'(busy));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sumator_seq.md
SUMATOR_SEQ -- requirements
Module: sumator_seq

Interface
REQ-001 Parameter NWORDS, default 4, number of 16-bit words per operand; legal range 2..8.
REQ-002 clk  input  1  single clock; every register updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising clk edge.
REQ-004 start  input  1  request one operation; accepted only in IDLE.
REQ-005 op  input  1  0 = add, 1 = subtract (a - b).
REQ-006 a  input  16*NWORDS  first operand; sampled when start is accepted.
REQ-007 b  input  16*NWORDS  second operand; sampled when start is accepted.
REQ-008 cin  input  1  carry-in for add; ignored for subtract.
REQ-009 busy  output  1  high while a word is being processed (RUN).
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 sum  output  16*NWORDS  registered result.
REQ-012 cout  output  1  carry out of MSB word; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow of the full-width result.

Function
REQ-014 States: IDLE, RUN, DONE.
REQ-015 Transitions: IDLE->RUN on start; RUN->RUN while word index < NWORDS-1; RUN->DONE after word NWORDS-1; DONE->IDLE unconditionally.
REQ-016 Accept edge k: latch a, b, op; b_eff = op ? ~b : b; carry register = op ? 1 : cin; word index = 0; sum and cout are not changed.
REQ-017 RUN edge: add word[idx] of a and b_eff plus the carry register; write the 16-bit result into sum[16*idx+15:16*idx]; load the carry register with the word carry-out; increment idx.
REQ-018 Latency: with start accepted at edge k, words are written at edges k+1..k+NWORDS; done=1 in the cycle after edge k+NWORDS.
REQ-019 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-020 cout and ovf are updated at edge k+NWORDS.
REQ-021 ovf = (MSB a == MSB b_eff) AND (MSB sum != MSB a).
REQ-022 sum, cout and ovf hold their values from the DONE cycle until the next accepted start completes its first word; sum words are overwritten progressively.
REQ-023 start in RUN or DONE is ignored; no queuing, and the operand registers are unchanged.
REQ-024 start held high continuously gives back-to-back operations with exactly one IDLE cycle between done and the next RUN.
REQ-025 Changing a, b, op or cin after acceptance has no effect on the operation in flight.

Reset
REQ-026 rst=1 at an edge: state=IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; operand, carry and index registers cleared.
REQ-027 rst=1 overrides start at the same edge, and aborts an operation in progress.
REQ-028 The first start is accepted at the first edge with rst=0 and start=1.

Structure
REQ-029 A shared package holds the word width constant (16), the state enum (IDLE/RUN/DONE) and the op encoding (OP_ADD=0, OP_SUB=1).
REQ-030 The word adder is one instance of the existing 16-bit carry-lookahead adder sumator16b, with its P/G/C debug outputs left unconnected; there are no other sub-modules.
REQ-031 All outputs are driven directly from registers; there is no combinational path from inputs to outputs.

Verification (NWORDS=4)
REQ-032 Add a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0; done 4 cycles after the accept edge; busy high for exactly 4 cycles.
REQ-033 Subtract a=0x5, b=0x7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-034 Add a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-035 Add a=0xFFFF, b=0, cin=1 -> sum=0x0000_0000_0001_0000, showing the carry crossing a word boundary; then pulse start again while busy with different operands -> pulse ignored and result unchanged.
REQ-036 Start an add, assert rst at the second RUN cycle -> next cycle busy=0, done=0, sum=0; then a start with a=3, b=4, cin=0 -> sum=7, with normal latency.
